// File: rtl/l1_l2_req_arb_if.sv
// Handshake bundle between the per-stream L1 refill requesters, the arbiter and the L2 controller.
// The arbiter binds to the slave modport; the surrounding environment binds to master.
interface l1_l2_req_arb_if #(
  parameter int nstrms    = 64,
  parameter int noutst    = 8,
  parameter int sid_width = $clog2(nstrms),
  parameter int cnt_width = $clog2(noutst + 1)
);
  // Every channel is valid/ready: a transfer happens on a rising clk edge where
  // valid and ready are both high; valid never waits for ready, and the payload
  // stays stable while valid is high and ready is low.
  logic [nstrms-1:0]    i_req_v;
  logic [nstrms-1:0]    i_req_r;
  logic                 o_cmd_v;
  logic                 o_cmd_r;
  logic [sid_width-1:0] o_cmd_sid;
  logic                 i_cpl_v;
  logic                 i_cpl_r;
  logic [nstrms-1:0]    o_rsp_v;
  logic [nstrms-1:0]    o_rsp_r;
  logic [cnt_width-1:0] o_outst;
  logic                 o_err;

  modport slave (
    input  i_req_v,
    output i_req_r,
    output o_cmd_v,
    input  o_cmd_r,
    output o_cmd_sid,
    input  i_cpl_v,
    output i_cpl_r,
    output o_rsp_v,
    input  o_rsp_r,
    output o_outst,
    output o_err
  );

  modport master (
    output i_req_v,
    input  i_req_r,
    input  o_cmd_v,
    output o_cmd_r,
    input  o_cmd_sid,
    output i_cpl_v,
    input  i_cpl_r,
    input  o_rsp_v,
    output o_rsp_r,
    input  o_outst,
    input  o_err
  );
endinterface

// File: rtl/l1_l2_req_arb.sv
// Round-robin arbiter sharing the L2 cacheline-read port among nstrms L1 streams, with an
// in-order sid FIFO routing completions back. Define L1_L2_ARB_STATS_EN to add grant/stall counters.
module l1_l2_req_arb #(
  parameter int nstrms    = 64,
  parameter int sid_width = $clog2(nstrms),
  parameter int noutst    = 8,
  parameter int cnt_width = $clog2(noutst + 1)
) (
  input  logic                clk,
  input  logic                reset,
  l1_l2_req_arb_if.slave      bus
`ifdef L1_L2_ARB_STATS_EN
  ,
  output logic [31:0]         o_grant_cnt,
  output logic [31:0]         o_stall_cnt
`endif
);

  localparam int ptr_width = $clog2(noutst);
  localparam logic [cnt_width-1:0] full_cnt = cnt_width'(noutst);

  logic [sid_width-1:0] rr_q, rr_d;
  logic                 cmd_v_q, cmd_v_d;
  logic [sid_width-1:0] cmd_sid_q, cmd_sid_d;
  logic [cnt_width-1:0] outst_q, outst_d;
  logic                 err_q, err_d;
  logic [ptr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [sid_width-1:0] fifo_q [noutst];
  logic [sid_width-1:0] fifo_d [noutst];

  logic                 cmd_free;
  logic                 grant_en;
  logic                 found;
  logic [sid_width-1:0] g;
  logic [sid_width-1:0] idx;
  logic                 push;
  logic                 pop;
  logic                 nonempty;
  logic [sid_width-1:0] h;

  assign cmd_free = !cmd_v_q || bus.o_cmd_r;
  // A pop in the same cycle does not free a slot for a grant while full.
  assign grant_en = cmd_free && (outst_q != full_cnt);

  // Search upward from rr_q; the sid_width adder wraps mod nstrms for free.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int i = 0; i < nstrms; i++) begin
      idx = rr_q + sid_width'(i);
      if (!found && bus.i_req_v[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  assign push     = grant_en && found;
  assign nonempty = (outst_q != '0);
  assign h        = fifo_q[rd_ptr_q];
  assign pop      = bus.i_cpl_v && nonempty && bus.o_rsp_r[h];

  always_comb begin
    bus.i_req_r = '0;
    if (push) bus.i_req_r = nstrms'(1) << g;
  end

  always_comb begin
    bus.o_rsp_v = '0;
    if (bus.i_cpl_v && nonempty) bus.o_rsp_v = nstrms'(1) << h;
  end

  assign bus.i_cpl_r   = nonempty && bus.o_rsp_r[h];
  assign bus.o_cmd_v   = cmd_v_q;
  assign bus.o_cmd_sid = cmd_sid_q;
  assign bus.o_outst   = outst_q;
  assign bus.o_err     = err_q;

  always_comb begin
    rr_d      = rr_q;
    cmd_v_d   = cmd_v_q;
    cmd_sid_d = cmd_sid_q;
    outst_d   = outst_q;
    err_d     = err_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    for (int i = 0; i < noutst; i++) fifo_d[i] = fifo_q[i];

    if (push) begin
      cmd_v_d          = 1'b1;
      cmd_sid_d        = g;
      rr_d             = g + 1'b1;
      fifo_d[wr_ptr_q] = g;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end else if (bus.o_cmd_r) begin
      cmd_v_d = 1'b0;
    end

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (bus.i_cpl_v && !nonempty) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= '0;
      cmd_v_q   <= 1'b0;
      cmd_sid_q <= '0;
      outst_q   <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < noutst; i++) fifo_q[i] <= '0;
    end else begin
      rr_q      <= rr_d;
      cmd_v_q   <= cmd_v_d;
      cmd_sid_q <= cmd_sid_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      for (int i = 0; i < noutst; i++) fifo_q[i] <= fifo_d[i];
    end
  end

`ifdef L1_L2_ARB_STATS_EN
  logic [31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // A stall is a cycle with any request pending while grants are blocked.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push) grant_cnt_d = grant_cnt_q + 32'd1;
    if ((|bus.i_req_v) && !grant_en) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_grant_cnt = grant_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_l1_l2_req_arb.sv
// Directed bench for l1_l2_req_arb: a vector table walked cycle by cycle plus hand-written
// sequences for fairness, backpressure, full, reset and (with L1_L2_ARB_STATS_EN) the counters.
module tb_l1_l2_req_arb;
  localparam logic [63:0] ALL = '1;

  typedef struct {
    logic [63:0] req_v;
    logic        cmd_r;
    logic        cpl_v;
    logic [63:0] rsp_r;
    logic [63:0] e_req_r;
    logic        e_cmd_v;
    logic [5:0]  e_sid;
    logic [63:0] e_rsp_v;
    logic        e_cpl_r;
    logic [3:0]  e_outst;
    logic        e_err;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[13];

  l1_l2_req_arb_if #(.nstrms(64), .noutst(8)) bus ();

`ifdef L1_L2_ARB_STATS_EN
  logic [31:0] grant_cnt;
  logic [31:0] stall_cnt;
`endif

  l1_l2_req_arb #(.nstrms(64), .noutst(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef L1_L2_ARB_STATS_EN
    ,
    .o_grant_cnt (grant_cnt),
    .o_stall_cnt (stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] b(input int n);
    logic [63:0] one;
    one = 64'd1;
    return one << n;
  endfunction

  function automatic vec_t mk(input logic [63:0] req_v, input logic cmd_r, input logic cpl_v,
                              input logic [63:0] rsp_r, input logic [63:0] e_req_r,
                              input logic e_cmd_v, input logic [5:0] e_sid,
                              input logic [63:0] e_rsp_v, input logic e_cpl_r,
                              input logic [3:0] e_outst, input logic e_err);
    vec_t v;
    v.req_v = req_v;  v.cmd_r = cmd_r;  v.cpl_v = cpl_v;  v.rsp_r = rsp_r;
    v.e_req_r = e_req_r;  v.e_cmd_v = e_cmd_v;  v.e_sid = e_sid;  v.e_rsp_v = e_rsp_v;
    v.e_cpl_r = e_cpl_r;  v.e_outst = e_outst;  v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver: inputs change at negedge, outputs are sampled 1ns later
  task automatic apply(input logic [63:0] req_v, input logic cmd_r, input logic cpl_v,
                       input logic [63:0] rsp_r);
    @(negedge clk);
    bus.i_req_v = req_v;
    bus.o_cmd_r = cmd_r;
    bus.i_cpl_v = cpl_v;
    bus.o_rsp_r = rsp_r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.i_req_v = '0;
    bus.o_cmd_r = 1'b1;
    bus.i_cpl_v = 1'b0;
    bus.o_rsp_r = ALL;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.i_req_v = '0;
    bus.o_cmd_r = 1'b1;
    bus.i_cpl_v = 1'b0;
    bus.o_rsp_r = ALL;

    // req_v, cmd_r, cpl_v, rsp_r | req_r, cmd_v, sid, rsp_v, cpl_r, outst, err
    vecs[0]  = mk('0,             1, 0, ALL,      '0,     0, 6'd0,  '0,    0, 4'd0, 0);
    vecs[1]  = mk(b(5),           1, 0, ALL,      b(5),   0, 6'd0,  '0,    0, 4'd0, 0);
    vecs[2]  = mk('0,             1, 0, ALL,      '0,     1, 6'd5,  '0,    1, 4'd1, 0);
    vecs[3]  = mk(b(2) | b(9),    1, 1, ALL,      b(9),   0, 6'd5,  b(5),  1, 4'd1, 0);
    vecs[4]  = mk(b(2) | b(9),    0, 0, ALL,      '0,     1, 6'd9,  '0,    1, 4'd1, 0);
    vecs[5]  = mk(b(2) | b(9),    1, 0, ALL,      b(2),   1, 6'd9,  '0,    1, 4'd1, 0);
    vecs[6]  = mk('0,             1, 1, ~b(9),    '0,     1, 6'd2,  b(9),  0, 4'd2, 0);
    vecs[7]  = mk('0,             1, 1, ALL,      '0,     0, 6'd2,  b(9),  1, 4'd2, 0);
    vecs[8]  = mk('0,             1, 1, ALL,      '0,     0, 6'd2,  b(2),  1, 4'd1, 0);
    vecs[9]  = mk('0,             1, 1, ALL,      '0,     0, 6'd2,  '0,    0, 4'd0, 0);
    vecs[10] = mk('0,             1, 0, ALL,      '0,     0, 6'd2,  '0,    0, 4'd0, 1);
    vecs[11] = mk(b(0) | b(63),   1, 0, ALL,      b(63),  0, 6'd2,  '0,    0, 4'd0, 1);
    vecs[12] = mk(b(0) | b(63),   1, 0, ALL,      b(0),   1, 6'd63, '0,    1, 4'd1, 1);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].req_v, vecs[i].cmd_r, vecs[i].cpl_v, vecs[i].rsp_r);
      chk($sformatf("v%0d.req_r", i), bus.i_req_r, vecs[i].e_req_r);
      chk($sformatf("v%0d.cmd_v", i), 64'(bus.o_cmd_v), 64'(vecs[i].e_cmd_v));
      chk($sformatf("v%0d.sid", i), 64'(bus.o_cmd_sid), 64'(vecs[i].e_sid));
      chk($sformatf("v%0d.rsp_v", i), bus.o_rsp_v, vecs[i].e_rsp_v);
      chk($sformatf("v%0d.cpl_r", i), 64'(bus.i_cpl_r), 64'(vecs[i].e_cpl_r));
      chk($sformatf("v%0d.outst", i), 64'(bus.o_outst), 64'(vecs[i].e_outst));
      chk($sformatf("v%0d.err", i), 64'(bus.o_err), 64'(vecs[i].e_err));
    end

    // fairness: all streams requesting, grants rotate 0..63 then 0
    do_reset();
    for (int k = 0; k < 65; k++) begin
      apply(ALL, 1, 1, ALL);
      chk($sformatf("fair%0d.req_r", k), bus.i_req_r, b(k % 64));
      if (k > 0) chk($sformatf("fair%0d.sid", k), 64'(bus.o_cmd_sid), 64'((k - 1) % 64));
    end

    // backpressure: one grant, then held command and no further grants
    do_reset();
    apply(b(3), 0, 0, ALL);
    chk("bp.first_grant", bus.i_req_r, b(3));
    for (int k = 0; k < 10; k++) begin
      apply(b(3), 0, 0, ALL);
      chk($sformatf("bp%0d.req_r", k), bus.i_req_r, '0);
      chk($sformatf("bp%0d.sid", k), 64'(bus.o_cmd_sid), 64'd3);
      chk($sformatf("bp%0d.cmd_v", k), 64'(bus.o_cmd_v), 64'd1);
    end
    chk("bp.outst", 64'(bus.o_outst), 64'd1);
    apply(b(3), 1, 0, ALL);
    chk("bp.accept_regrant", bus.i_req_r, b(3));

    // full: eight grants with no completions, then pop frees a slot a cycle later
    do_reset();
    for (int k = 0; k < 8; k++) begin
      apply(b(1), 1, 0, ALL);
      chk($sformatf("full_g%0d", k), bus.i_req_r, b(1));
    end
    for (int k = 0; k < 3; k++) begin
      apply(b(1), 1, 0, ALL);
      chk($sformatf("full_s%0d.outst", k), 64'(bus.o_outst), 64'd8);
      chk($sformatf("full_s%0d.req_r", k), bus.i_req_r, '0);
    end
`ifdef L1_L2_ARB_STATS_EN
    apply(b(1), 1, 0, ALL);
    chk("stats.grant_cnt", 64'(grant_cnt), 64'd8);
    chk("stats.stall_cnt", 64'(stall_cnt), 64'd3);
`endif
    apply(b(1), 1, 1, ALL);
    chk("full_pop.req_r", bus.i_req_r, '0);
    chk("full_pop.rsp_v", bus.o_rsp_v, b(1));
    apply(b(1), 1, 0, ALL);
    chk("full_after.outst", 64'(bus.o_outst), 64'd7);
    chk("full_after.req_r", bus.i_req_r, b(1));

    // spurious completion, pending command, then asynchronous reset mid-cycle
    do_reset();
    apply('0, 1, 1, ALL);
    apply(b(3), 0, 0, ALL);
    apply(b(3), 0, 0, ALL);
    chk("rst_pre.err", 64'(bus.o_err), 64'd1);
    chk("rst_pre.cmd_v", 64'(bus.o_cmd_v), 64'd1);
    chk("rst_pre.outst", 64'(bus.o_outst), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.err", 64'(bus.o_err), 64'd0);
    chk("rst_mid.cmd_v", 64'(bus.o_cmd_v), 64'd0);
    chk("rst_mid.outst", 64'(bus.o_outst), 64'd0);
`ifdef L1_L2_ARB_STATS_EN
    chk("rst_mid.grant_cnt", 64'(grant_cnt), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
